// File: rtl/fma16_pkg.sv
// Shared types and constants for the fma16 issue/retire stage.
package fma16_pkg;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] z;
        logic [3:0]  op;
        logic [1:0]  rm;
        logic        use_acc;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

    // Bit positions inside op = {mul, add, negp, negz}
    localparam int OP_MUL  = 3;
    localparam int OP_ADD  = 2;
    localparam int OP_NEGP = 1;
    localparam int OP_NEGZ = 0;

    localparam int FLG_NV = 3;
    localparam int FLG_OF = 2;
    localparam int FLG_UF = 1;
    localparam int FLG_NX = 0;

    localparam logic [1:0] RM_RZ  = 2'b00;
    localparam logic [1:0] RM_RNE = 2'b01;
    localparam logic [1:0] RM_RD  = 2'b10;
    localparam logic [1:0] RM_RU  = 2'b11;

    localparam logic [15:0] FP16_ZERO = 16'h0000;

endpackage

// File: rtl/fma16_cmd_fifo.sv
// Command FIFO for fma16_issue_seq: DEPTH entries, extra-MSB pointers.
module fma16_cmd_fifo
    import fma16_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [CMD_W-1:0] wr_cmd,
    output logic [CMD_W-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
        $error("fma16_cmd_fifo: DEPTH must be a power of 2 and >= 2");
    end

    logic [CMD_W-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // Storage is cleared too, so the head drives zeros after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= wr_cmd;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    assign head  = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = ((wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}});

endmodule

// File: rtl/fma16_issue_seq.sv
// Issue/retire stage around the combinational fma16 datapath.
// Optional same-edge bypass when idle: define FMA16_ISSUE_BYPASS_EN.
module fma16_issue_seq
    import fma16_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_x,
    input  logic [15:0] in_y,
    input  logic [15:0] in_z,
    input  logic [3:0]  in_op,
    input  logic [1:0]  in_rm,
    input  logic        in_use_acc,
    output logic [15:0] fma_x,
    output logic [15:0] fma_y,
    output logic [15:0] fma_z,
    output logic        fma_mul,
    output logic        fma_add,
    output logic        fma_negp,
    output logic        fma_negz,
    output logic [1:0]  fma_rm,
    input  logic [15:0] fma_result,
    input  logic [3:0]  fma_flags,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_result,
    output logic [3:0]  out_flags,
    output logic [15:0] acc_value,
    input  logic        acc_clr,
    output logic [3:0]  sticky_flags,
    input  logic        flags_clr
);

    cmd_t in_cmd;
    cmd_t head;
    cmd_t sel;

    logic full;
    logic empty;
    logic out_free;
    logic bypass;
    logic push;
    logic pop;
    logic issue;

    assign in_cmd = '{
        x:       in_x,
        y:       in_y,
        z:       in_z,
        op:      in_op,
        rm:      in_rm,
        use_acc: in_use_acc
    };

    fma16_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .push   (push),
        .pop    (pop),
        .wr_cmd (in_cmd),
        .head   (head),
        .full   (full),
        .empty  (empty)
    );

    assign in_ready = !full;
    assign out_free = !out_valid || out_ready;

`ifdef FMA16_ISSUE_BYPASS_EN
    assign bypass = empty && out_free && in_valid;
`else
    assign bypass = 1'b0;
`endif

    assign push  = in_valid && in_ready && !bypass;
    assign pop   = !empty && out_free;
    assign issue = pop || bypass;
    assign sel   = bypass ? in_cmd : head;

    // Accumulator chaining replaces z and forces the addend on.
    assign fma_x    = sel.x;
    assign fma_y    = sel.y;
    assign fma_z    = sel.use_acc ? acc_value : sel.z;
    assign fma_mul  = sel.op[OP_MUL];
    assign fma_add  = sel.op[OP_ADD] | sel.use_acc;
    assign fma_negp = sel.op[OP_NEGP];
    assign fma_negz = sel.op[OP_NEGZ];
    assign fma_rm   = sel.rm;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_result <= FP16_ZERO;
            out_flags  <= '0;
        end else if (issue) begin
            out_valid  <= 1'b1;
            out_result <= fma_result;
            out_flags  <= fma_flags;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_value <= FP16_ZERO;
        end else if (acc_clr) begin
            acc_value <= FP16_ZERO;
        end else if (issue) begin
            acc_value <= fma_result;
        end
    end

    // A clear on a retire edge keeps the retiring op's flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sticky_flags <= '0;
        end else if (flags_clr) begin
            sticky_flags <= issue ? fma_flags : 4'b0000;
        end else if (issue) begin
            sticky_flags <= sticky_flags | fma_flags;
        end
    end

endmodule

// File: tb/tb_fma16_issue_seq.sv
// Directed bench for fma16_issue_seq with a table-driven fma16 stub.
module tb_fma16_issue_seq;
    import fma16_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_x, in_y, in_z;
    logic [3:0]  in_op;
    logic [1:0]  in_rm;
    logic        in_use_acc;
    logic [15:0] fma_x, fma_y, fma_z;
    logic        fma_mul, fma_add, fma_negp, fma_negz;
    logic [1:0]  fma_rm;
    logic [15:0] fma_result;
    logic [3:0]  fma_flags;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic [3:0]  out_flags;
    logic [15:0] acc_value;
    logic        acc_clr;
    logic [3:0]  sticky_flags;
    logic        flags_clr;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    logic [19:0] rq[$];
    int          cq[$];

    always #5 clk = ~clk;

    fma16_issue_seq #(.DEPTH(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_x         (in_x),
        .in_y         (in_y),
        .in_z         (in_z),
        .in_op        (in_op),
        .in_rm        (in_rm),
        .in_use_acc   (in_use_acc),
        .fma_x        (fma_x),
        .fma_y        (fma_y),
        .fma_z        (fma_z),
        .fma_mul      (fma_mul),
        .fma_add      (fma_add),
        .fma_negp     (fma_negp),
        .fma_negz     (fma_negz),
        .fma_rm       (fma_rm),
        .fma_result   (fma_result),
        .fma_flags    (fma_flags),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_flags    (out_flags),
        .acc_value    (acc_value),
        .acc_clr      (acc_clr),
        .sticky_flags (sticky_flags),
        .flags_clr    (flags_clr)
    );

    // Known fp16 cases from a table; anything else gets a tagged hash.
    always_comb begin
        logic fmadd;
        fmadd = fma_mul && fma_add && !fma_negp && !fma_negz;
        fma_flags  = 4'b0000;
        fma_result = (fma_x + fma_y) ^ fma_z
                   ^ {fma_mul, fma_add, fma_negp, fma_negz, fma_rm, 10'h000};
        if (fmadd && fma_x == 16'h3C00 && fma_y == 16'h3C00 && fma_z == 16'h0000) begin
            fma_result = 16'h3C00;
        end else if (fmadd && fma_x == 16'h3C00 && fma_y == 16'h4000 && fma_z == 16'h0000) begin
            fma_result = 16'h4000;
        end else if (fmadd && fma_x == 16'h3C00 && fma_y == 16'h4000 && fma_z == 16'h4000) begin
            fma_result = 16'h4400;
        end else if (fmadd && fma_x == 16'h3C00 && fma_y == 16'h4000 && fma_z == 16'h4400) begin
            fma_result = 16'h4600;
        end else if (fmadd && fma_x == 16'h7C00 && fma_y == 16'h0000 && fma_z == 16'h0000) begin
            fma_result = 16'h7E00;
            fma_flags  = 4'b1000;
        end else if (fmadd && fma_x == 16'h7BFF && fma_y == 16'h4000 && fma_z == 16'h0000
                     && fma_rm == RM_RNE) begin
            fma_result = 16'h7C00;
            fma_flags  = 4'b0101;
        end
    end

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (out_valid && out_ready) begin
            rq.push_back({out_result, out_flags});
            cq.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                        input logic [3:0] op, input logic use_acc);
        int n;
        in_valid = 1'b1;
        in_x = x;
        in_y = y;
        in_z = z;
        in_op = op;
        in_rm = RM_RNE;
        in_use_acc = use_acc;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (n == 20) check("send_timeout", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    function automatic logic [15:0] bp_x(input int i);
        return 16'h0100 * 16'(i + 1) + 16'h0011;
    endfunction

    function automatic logic [15:0] bp_exp(input int i);
        return (bp_x(i) + 16'h0002) ^ 16'hC400;
    endfunction

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        in_x = '0;
        in_y = '0;
        in_z = '0;
        in_op = '0;
        in_rm = '0;
        in_use_acc = 1'b0;
        out_ready = 1'b1;
        acc_clr = 1'b0;
        flags_clr = 1'b0;
        tick();
        tick();
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_result", {16'd0, out_result}, 32'd0);
        check("rst_acc", {16'd0, acc_value}, 32'd0);
        check("rst_sticky", {28'd0, sticky_flags}, 32'd0);
        check("rst_fma_ctl", {20'd0, fma_x, fma_mul, fma_add, fma_negp, fma_negz},
              32'd0);
        reset = 1'b0;
        tick();

        // Basic op and latency
        send(16'h3C00, 16'h3C00, 16'h0000, 4'b1100, 1'b0);
`ifdef FMA16_ISSUE_BYPASS_EN
        check("lat_k", {31'd0, out_valid}, 32'd1);
        check("basic_res_k", {12'd0, out_result, out_flags}, {12'd0, 16'h3C00, 4'h0});
        tick();
`else
        check("lat_k", {31'd0, out_valid}, 32'd0);
        tick();
        check("lat_k1", {31'd0, out_valid}, 32'd1);
        check("basic_res", {12'd0, out_result, out_flags}, {12'd0, 16'h3C00, 4'h0});
        tick();
`endif
        check("basic_drop", {31'd0, out_valid}, 32'd0);

        // Accumulate chain; second command relies on forced add
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        check("acc_clr", {16'd0, acc_value}, 32'd0);
        rq.delete();
        cq.delete();
        send(16'h3C00, 16'h4000, 16'h1234, 4'b1100, 1'b1);
        send(16'h3C00, 16'h4000, 16'h1234, 4'b1000, 1'b1);
        send(16'h3C00, 16'h4000, 16'h1234, 4'b1100, 1'b1);
        repeat (4) tick();
        check("acc_cnt", rq.size(), 32'd3);
        if (rq.size() == 3) begin
            check("acc_r0", {12'd0, rq[0]}, {12'd0, 16'h4000, 4'h0});
            check("acc_r1", {12'd0, rq[1]}, {12'd0, 16'h4400, 4'h0});
            check("acc_r2", {12'd0, rq[2]}, {12'd0, 16'h4600, 4'h0});
            check("acc_b2b", cq[2] - cq[0], 32'd2);
        end
        check("acc_final", {16'd0, acc_value}, 32'h4600);

        // Invalid op, overflow and sticky flags
        flags_clr = 1'b1;
        tick();
        flags_clr = 1'b0;
        send(16'h7C00, 16'h0000, 16'h0000, 4'b1100, 1'b0);
        repeat (3) tick();
        check("nv_res", {12'd0, out_result, out_flags}, {12'd0, 16'h7E00, 4'b1000});
        check("nv_sticky", {28'd0, sticky_flags}, 32'b1000);
        send(16'h7BFF, 16'h4000, 16'h0000, 4'b1100, 1'b0);
        repeat (3) tick();
        check("of_res", {12'd0, out_result, out_flags}, {12'd0, 16'h7C00, 4'b0101});
        check("of_sticky", {28'd0, sticky_flags}, 32'b1101);
        check("of_nx_bit", {31'd0, sticky_flags[FLG_NX]}, 32'd1);
        flags_clr = 1'b1;
        tick();
        flags_clr = 1'b0;
        check("flags_clr", {28'd0, sticky_flags}, 32'd0);

        // Clears landing on a retire edge
        out_ready = 1'b0;
        send(16'h7C00, 16'h0000, 16'h0000, 4'b1100, 1'b0);
        repeat (2) tick();
        send(16'h7BFF, 16'h4000, 16'h0000, 4'b1100, 1'b0);
        repeat (2) tick();
        check("hold_res", {12'd0, out_result, out_flags}, {12'd0, 16'h7E00, 4'b1000});
        check("hold_sticky", {28'd0, sticky_flags}, 32'b1000);
        out_ready = 1'b1;
        flags_clr = 1'b1;
        acc_clr = 1'b1;
        tick();
        flags_clr = 1'b0;
        acc_clr = 1'b0;
        check("clr_retire_res", {16'd0, out_result}, 32'h7C00);
        check("clr_retire_sticky", {28'd0, sticky_flags}, 32'b0101);
        check("clr_retire_acc", {16'd0, acc_value}, 32'd0);
        tick();
        check("clr_drop", {31'd0, out_valid}, 32'd0);

        // Backpressure: 1 in output register + 4 in FIFO
        rq.delete();
        cq.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send(bp_x(i), 16'h0002, 16'h0000, 4'b1100, 1'b0);
        end
        in_valid = 1'b1;
        in_x = bp_x(5);
        in_y = 16'h0002;
        in_z = 16'h0000;
        in_op = 4'b1100;
        in_rm = RM_RNE;
        in_use_acc = 1'b0;
        check("bp_full", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            check("bp_stable", {15'd0, out_valid, out_result}, {15'd0, 1'b1, bp_exp(0)});
            tick();
        end
        check("bp_still_full", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        send(bp_x(5), 16'h0002, 16'h0000, 4'b1100, 1'b0);
        repeat (8) tick();
        check("bp_cnt", rq.size(), 32'd6);
        if (rq.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                check($sformatf("bp_r%0d", i), {12'd0, rq[i]}, {12'd0, bp_exp(i), 4'h0});
            end
            check("bp_drain_rate", cq[4] - cq[1], 32'd3);
        end

        // Reset with work in flight
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(bp_x(i), 16'h0002, 16'h0000, 4'b1100, 1'b0);
        end
        check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        rq.delete();
        reset = 1'b1;
        #1;
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_ready", {31'd0, in_ready}, 32'd1);
        check("mid_rst_acc", {16'd0, acc_value}, 32'd0);
        check("mid_rst_sticky", {28'd0, sticky_flags}, 32'd0);
        tick();
        reset = 1'b0;
        out_ready = 1'b1;
        repeat (6) tick();
        check("post_rst_stale", rq.size(), 32'd0);
        check("post_rst_valid", {31'd0, out_valid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
